// File: rtl/muldiv_if.sv
// Handshake and result bus between the CPU control and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide sharing one 2*WIDTH shift datapath.
// Owns the HI/LO result registers; one bit of work per RUN cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, done_q, div_zero_q, div_zero_d;

  logic               is_div, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, rem, quo;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // In PREP the raw dividend/multiplicand still sits in the low half of acc_q.
  assign a_neg = is_signed & acc_q[WIDTH-1];
  assign b_neg = is_signed & b_q[WIDTH-1];
  assign a_mag = a_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign b_mag = b_neg ? -b_q : b_q;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Remainder stays below the divisor, so bit WIDTH of diff is a clean borrow.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, b_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign rem = acc_q[2*WIDTH-1:WIDTH];
  assign quo = acc_q[WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StPrep;
          op_d    = bus.op;
          b_d     = bus.b;
          acc_d   = {{WIDTH{1'b0}}, bus.a};
        end
      end
      StPrep: begin
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        b_d       = b_mag;
        acc_d     = {{WIDTH{1'b0}}, a_mag};
        cnt_d     = CW'(WIDTH);
        if (is_div && (b_q == '0)) begin
          state_d    = StDone;
          div_zero_d = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StFix;
      end
      StFix: begin
        if (is_div) begin
          hi_d = neg_rem_q ? -rem : rem;
          lo_d = neg_res_q ? -quo : quo;
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32; latency counts the start edge as edge 1.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  bit   busy_ok;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch an op and wait for done; a/b/op are scrambled while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int l, output bit bok);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    l   = 1;
    bok = 1'b1;
    while (!bus.done && l < 100) begin
      if (!bus.busy) bok = 1'b0;
      bus.a  = $urandom();
      bus.b  = $urandom();
      bus.op = 2'($urandom_range(3));
      tick();
      l++;
    end
    if (!bus.busy) bok = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 32'h1234;
    bus.b     = 32'h5;
    tick();
    tick();
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_divz", {63'd0, bus.div_zero}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();

    // 1: signed multiply -3 * 7
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, busy_ok);
    chk("t1_latency", 64'(lat), 64'd35);
    chk("t1_busy", {63'd0, busy_ok}, 64'd1);
    chk("t1_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("t1_divz", {63'd0, bus.div_zero}, 64'd0);
    tick();
    chk("t1_done_pulse", {62'd0, bus.done, bus.busy}, 64'd0);

    // 2: unsigned then signed multiply of all-ones
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_ok);
    chk("t2u_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_ok);
    chk("t2s_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    tick();

    // 3: signed -7/2, with a start in the DONE cycle that must be ignored
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busy_ok);
    chk("t3s_latency", 64'(lat), 64'd35);
    chk("t3s_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    chk("t3_done_start_ign_a", {63'd0, bus.busy}, 64'd0);
    tick();
    chk("t3_done_start_ign_b", {63'd0, bus.busy}, 64'd0);
    run_op(2'b11, 32'd7, 32'd2, lat, busy_ok);
    chk("t3u_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    tick();

    // 4: divide by zero
    run_op(2'b10, 32'd5, 32'd0, lat, busy_ok);
    chk("t4_latency", 64'(lat), 64'd2);
    chk("t4_divz", {63'd0, bus.div_zero}, 64'd1);
    chk("t4_hilo_held", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    tick();
    chk("t4_divz_clear", {62'd0, bus.div_zero, bus.done}, 64'd0);

    // 5: most-negative / -1 wraps
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ok);
    chk("t5_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    chk("t5_divz", {63'd0, bus.div_zero}, 64'd0);
    tick();

    // 6a: start pulsed again at edge 10 is ignored
    bus.op    = 2'b01;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    repeat (8) begin
      tick();
      lat++;
    end
    bus.op    = 2'b01;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    bus.start = 1'b1;
    tick();
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    chk("t6a_latency", 64'(lat), 64'd35);
    chk("t6a_hilo", {bus.hi, bus.lo}, 64'd15);
    tick();

    // 6b: reset at edge 12 aborts
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6b_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6b_done", {63'd0, bus.done}, 64'd0);
    chk("t6b_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (30) tick();
    chk("t6b_no_late_done", {62'd0, bus.done, bus.busy}, 64'd0);

    // 6c: fresh signed divide 100 / -7 after reset
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, lat, busy_ok);
    chk("t6c_latency", 64'(lat), 64'd35);
    chk("t6c_busy", {63'd0, busy_ok}, 64'd1);
    chk("t6c_hilo", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFF2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
